// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled UART byte receiver with 3-sample majority vote per bit.
// Defining UART_RX_PARITY_EN adds one even-parity bit between data bit 7 and the stop bit.
module uart_byte_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] baud_set,
   input  logic       rs232_rx,
   output logic [7:0] data_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       uart_state
);

   localparam int unsigned DIV_W = 16;
   localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ / (9600 * 16));
   localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ / (19200 * 16));
   localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ / (38400 * 16));
   localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ / (57600 * 16));
   localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ / (115200 * 16));

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             sync1;
   logic             sync2;
   logic             hist;
   logic             start_edge;
   logic [3:0]       baud_q;
   logic [DIV_W-1:0] div_val;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_cnt;
   logic [2:0]       samp;
   logic [7:0]       shift_reg;
   logic             tick;
   logic             maj;
   logic             bit_end;
   logic             stop_end;
   logic             done_c;
   logic             restart_c;
`ifdef UART_RX_PARITY_EN
   logic             par_bit;
`endif

   // Two-flop synchroniser plus history flop for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist  <= 1'b1;
      end else begin
         sync1 <= rs232_rx;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign start_edge = ~sync2 & hist;

   always_comb begin
      div_val = DIV_9600;
      case (baud_q)
         4'd1:    div_val = DIV_19200;
         4'd2:    div_val = DIV_38400;
         4'd3:    div_val = DIV_57600;
         4'd4:    div_val = DIV_115200;
         default: div_val = DIV_9600;
      endcase
   end

   assign tick     = (state != IDLE) && (div_cnt == div_val - DIV_W'(1));
   assign maj      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
   assign bit_end  = tick && (tick_cnt == 4'd15);
   assign stop_end = tick && (tick_cnt == 4'd10);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (start_edge) next_state = START;
         START:  if (bit_end) next_state = maj ? IDLE : DATA;
         DATA:   if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                 end
         PARITY: if (bit_end) next_state = STOP;
         STOP:   if (stop_end) next_state = start_edge ? START : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Frame completes at mid-stop so a start edge right after the stop bit is not missed
   always_comb begin
      done_c    = 1'b0;
      restart_c = 1'b0;
      case (state)
         IDLE: restart_c = start_edge;
         STOP: begin
            done_c    = stop_end;
            restart_c = stop_end && start_edge;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q    <= 4'd0;
         div_cnt   <= '0;
         tick_cnt  <= 4'd0;
         bit_cnt   <= 3'd0;
         samp      <= 3'b111;
         shift_reg <= 8'h00;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else if (restart_c) begin
         baud_q   <= baud_set;
         div_cnt  <= '0;
         tick_cnt <= 4'd0;
         bit_cnt  <= 3'd0;
      end else if (state != IDLE) begin
         if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd7) samp[0] <= sync2;
            if (tick_cnt == 4'd8) samp[1] <= sync2;
            if (tick_cnt == 4'd9) samp[2] <= sync2;
            if (bit_end && (state == DATA)) begin
               shift_reg <= {maj, shift_reg[7:1]};
               bit_cnt   <= bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (bit_end && (state == PARITY)) par_bit <= maj;
`endif
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_byte  <= 8'h00;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         uart_state <= 1'b0;
      end else begin
         rx_done    <= done_c;
         uart_state <= (next_state != IDLE);
         if (done_c) begin
            data_byte <= shift_reg;
            frame_err <= ~maj;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shift_reg) ^ par_bit;
`else
            parity_err <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx; drives serial frames and
// compares each rx_done against the queued expected byte and flags.
`timescale 1ns/1ps
module tb_uart_byte_rx;

   localparam int unsigned CLK_FREQ = 10_000_000;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] baud_set = 4'd4;
   logic       rs232_rx = 1'b1;
   logic [7:0] data_byte;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       uart_state;

   typedef struct { logic [7:0] d; logic fe; logic pe; } exp_t;
   typedef struct { logic [7:0] d; logic fe; logic pe; int cyc; } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   state_low_cnt = 0;
   int   wide_cnt = 0;
   int   t_start = 0;
   logic in_frame = 1'b0;
   logic prev_done = 1'b0;
   bit   scramble_baud = 1'b0;

   uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_set   (baud_set),
      .rs232_rx   (rs232_rx),
      .data_byte  (data_byte),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .uart_state (uart_state)
   );

   always #50 clk = ~clk;

   // Monitor: records every rx_done and watches uart_state inside frames
   always @(negedge clk) begin : mon
      obs_t o;
      cyc = cyc + 1;
      if (in_frame && !uart_state) state_low_cnt = state_low_cnt + 1;
      if (rx_done && prev_done) wide_cnt = wide_cnt + 1;
      prev_done = rx_done;
      if (rx_done) begin
         o.d = data_byte; o.fe = frame_err; o.pe = parity_err; o.cyc = cyc;
         obs_q.push_back(o);
      end
   end

   function automatic int div_for(input logic [3:0] b);
      int rate;
      case (b)
         4'd1: rate = 19200;
         4'd2: rate = 38400;
         4'd3: rate = 57600;
         4'd4: rate = 115200;
         default: rate = 9600;
      endcase
      return int'(CLK_FREQ / (rate * 16));
   endfunction

   function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d = d; e.fe = fe; e.pe = pe;
      return e;
   endfunction

   task automatic idle(input int nbits);
      rs232_rx = 1'b1;
      repeat (nbits * 16 * div_for(baud_set)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input int abort_bit);
      int bc;
      logic [3:0] b0;
      bc = 16 * div_for(baud_set);
      b0 = baud_set;
      rs232_rx = 1'b0;
      t_start = cyc;
      repeat (bc / 4) @(negedge clk);
      in_frame = 1'b1;
      if (scramble_baud) baud_set = b0 ^ 4'h4;
      repeat (bc - bc / 4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rs232_rx = d[i];
         if (i == abort_bit) begin
            repeat (bc / 2) @(negedge clk);
            in_frame = 1'b0;
            baud_set = b0;
            return;
         end
         repeat (bc) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rs232_rx = (^d) ^ par_flip;
      repeat (bc) @(negedge clk);
`endif
      rs232_rx = stop;
      repeat (bc / 2) @(negedge clk);
      in_frame = 1'b0;
      repeat (bc - bc / 2) @(negedge clk);
      baud_set = b0;
   endtask

   task automatic pop_pair(output exp_t e, output obs_t o, output bit got);
      int n;
      n = 0;
      got = 1'b0;
      while (obs_q.size() == 0 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         got = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_byte, rx_done, frame_err, parity_err, uart_state} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 000",
                  {data_byte, rx_done, frame_err, parity_err, uart_state});
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single;
      exp_t e; obs_t o; bit got; int lat; int nom; int tol;
      baud_set = 4'd4;
      state_low_cnt = 0;
      scramble_baud = 1'b1;
      exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      scramble_baud = 1'b0;
      idle(2);
      pop_pair(e, o, got);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL single_timeout: got no rx_done want one");
      end else begin
         checks++;
         if (o.d !== e.d) begin errors++; $display("FAIL single_data: got %h want %h", o.d, e.d); end
         checks++;
         if (o.fe !== e.fe) begin errors++; $display("FAIL single_frame_err: got %b want %b", o.fe, e.fe); end
         checks++;
         if (o.pe !== e.pe) begin errors++; $display("FAIL single_parity_err: got %b want %b", o.pe, e.pe); end
         lat = o.cyc - t_start;
         nom = ((19 + 2 * PAR_BITS) * 16 * div_for(4'd4)) / 2 + 3;
         tol = 8 * div_for(4'd4);
         checks++;
         if (lat < nom - tol || lat > nom + tol) begin
            errors++;
            $display("FAIL single_latency: got %0d clk want %0d +/- %0d", lat, nom, tol);
         end
      end
      checks++;
      if (state_low_cnt !== 0) begin
         errors++;
         $display("FAIL single_uart_state: got %0d low cycles in frame want 0", state_low_cnt);
      end
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL single_extra_done: got %0d extra pulses want 0", obs_q.size());
      end
   endtask

   task automatic test_back_to_back;
      exp_t e; obs_t o; bit got;
      baud_set = 4'd0;
      exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
      exp_q.push_back(mk(8'hFF, 1'b0, 1'b0));
      send_frame(8'h00, 1'b1, 1'b0, -1);
      send_frame(8'hFF, 1'b1, 1'b0, -1);
      idle(2);
      for (int k = 0; k < 2; k++) begin
         pop_pair(e, o, got);
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL b2b_frame%0d: got no rx_done want data %h", k, e.d);
         end else if (o.d !== e.d || o.fe !== e.fe) begin
            errors++;
            $display("FAIL b2b_frame%0d: got %h/%b want %h/%b", k, o.d, o.fe, e.d, e.fe);
         end
      end
   endtask

   task automatic test_rates;
      exp_t e; obs_t o; bit got;
      logic [3:0] rates [4];
      logic [7:0] d;
      rates = '{4'd1, 4'd2, 4'd3, 4'd12};
      foreach (rates[k]) begin
         baud_set = rates[k];
         d = 8'($urandom);
         exp_q.push_back(mk(d, 1'b0, 1'b0));
         send_frame(d, 1'b1, 1'b0, -1);
         idle(1);
         pop_pair(e, o, got);
         checks++;
         if (!got || o.d !== e.d || o.fe !== 1'b0) begin
            errors++;
            $display("FAIL rate_%0d: got %h/%b (seen %b) want %h/0", rates[k], o.d, o.fe, got, e.d);
         end
      end
   endtask

   task automatic test_glitch;
      int div;
      baud_set = 4'd4;
      div = div_for(4'd4);
      rs232_rx = 1'b0;
      repeat (3 * div) @(negedge clk);
      checks++;
      if (uart_state !== 1'b1) begin
         errors++;
         $display("FAIL glitch_start_seen: got uart_state %b want 1", uart_state);
      end
      rs232_rx = 1'b1;
      repeat (2 * 16 * div) @(negedge clk);
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL glitch_done: got %0d pulses want 0", obs_q.size());
      end
      checks++;
      if (uart_state !== 1'b0) begin
         errors++;
         $display("FAIL glitch_idle: got uart_state %b want 0", uart_state);
      end
   endtask

   task automatic test_frame_err;
      exp_t e; obs_t o; bit got;
      baud_set = 4'd4;
      exp_q.push_back(mk(8'h3C, 1'b1, 1'b0));
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      pop_pair(e, o, got);
      checks++;
      if (!got || o.d !== e.d || o.fe !== e.fe) begin
         errors++;
         $display("FAIL ferr_frame: got %h/%b (seen %b) want %h/%b", o.d, o.fe, got, e.d, e.fe);
      end
      repeat (2 * 16 * div_for(4'd4)) @(negedge clk);
      checks++;
      if (obs_q.size() !== 0 || uart_state !== 1'b0) begin
         errors++;
         $display("FAIL ferr_low_retrigger: got %0d pulses state %b want 0 pulses state 0",
                  obs_q.size(), uart_state);
      end
      idle(2);
      exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
      send_frame(8'h11, 1'b1, 1'b0, -1);
      idle(1);
      pop_pair(e, o, got);
      checks++;
      if (!got || o.d !== e.d || o.fe !== e.fe) begin
         errors++;
         $display("FAIL ferr_clean_frame: got %h/%b (seen %b) want %h/%b", o.d, o.fe, got, e.d, e.fe);
      end
   endtask

   task automatic test_reset_mid;
      exp_t e; obs_t o; bit got;
      baud_set = 4'd4;
      send_frame(8'h55, 1'b1, 1'b0, 4);
      rst = 1'b1;
      #1;
      checks++;
      if ({data_byte, rx_done, frame_err, parity_err, uart_state} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_outputs: got %h want 000",
                  {data_byte, rx_done, frame_err, parity_err, uart_state});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);
      exp_q.push_back(mk(8'h81, 1'b0, 1'b0));
      send_frame(8'h81, 1'b1, 1'b0, -1);
      idle(2);
      pop_pair(e, o, got);
      checks++;
      if (!got || o.d !== e.d || o.fe !== e.fe) begin
         errors++;
         $display("FAIL midreset_next: got %h/%b (seen %b) want %h/%b", o.d, o.fe, got, e.d, e.fe);
      end
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL midreset_extra: got %0d extra pulses want 0", obs_q.size());
      end
   endtask

   task automatic test_parity;
      exp_t e; obs_t o; bit got;
      logic pe_exp;
      baud_set = 4'd4;
      for (int k = 0; k < 2; k++) begin
`ifdef UART_RX_PARITY_EN
         pe_exp = k[0];
`else
         pe_exp = 1'b0;
`endif
         exp_q.push_back(mk(8'h07, 1'b0, pe_exp));
         send_frame(8'h07, 1'b1, k[0], -1);
         idle(1);
         pop_pair(e, o, got);
         checks++;
         if (!got || o.d !== e.d || o.pe !== e.pe) begin
            errors++;
            $display("FAIL parity_%0d: got %h/%b (seen %b) want %h/%b", k, o.d, o.pe, got, e.d, e.pe);
         end
      end
   endtask

   task automatic test_pulse_width;
      checks++;
      if (wide_cnt !== 0) begin
         errors++;
         $display("FAIL done_width: got %0d multi-cycle pulses want 0", wide_cnt);
      end
   endtask

   initial begin
      #(64'd30_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_rates();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_parity();
      test_pulse_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Receive side of the byte UART link; counterpart of the byte transmitter on the same 8N1 serial line.
- Samples the asynchronous rs232_rx line at 16x the selected baud rate and takes a 3-sample majority vote at each bit centre.
- Delivers each received byte with a one-cycle rx_done strobe and a frame-error flag.
- Sits between the board RX pin and user logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive the oversample dividers.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- baud_set  input  4  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..15=9600.
- rs232_rx  input  1  serial line, idle high, asynchronous to clk.
- data_byte  output  8  last received byte.
- rx_done  output  1  one-cycle pulse; data_byte is valid.
- frame_err  output  1  stop bit of the last byte sampled low; valid with rx_done.
- parity_err  output  1  parity mismatch on the last byte; valid with rx_done.
- uart_state  output  1  high while a frame is being received.

Behaviour:
- Reset values: data_byte=0, rx_done=0, frame_err=0, parity_err=0, uart_state=0. FSM=IDLE, all counters 0, synchroniser flops=1.
- Reset mid-frame aborts the frame immediately; no rx_done is produced for it.
- Input path:
  - 2-flop synchroniser, then one history flop.
  - A start edge is synchronised value 0 with history value 1.
- Oversample divider:
  - DIV = CLK_FREQ/(baud*16), integer-truncated. At 50 MHz: 325, 162, 81, 54, 27.
  - A tick is generated when the divider counter reaches DIV-1; the counter then wraps to 0.
  - baud_set is latched on the start edge; changes during a frame are ignored.
- Tick counter: 0..15 within each bit; bit counter tracks the current bit.
- Sampling: synchronised line captured on ticks 7, 8, 9; bit value = majority of the 3 samples.
- FSM states and transitions:
  - IDLE: uart_state=0. On start edge: clear divider and tick counter, latch baud, go to START.
  - START: at end of tick 15, majority 1 → false start, return to IDLE with no strobe. Otherwise go to DATA.
  - DATA: 8 bits, LSB first. Each bit is shifted into a shift register at the end of tick 15.
  - DATA exit: after bit 7, go to PARITY if UART_RX_PARITY_EN is defined, else go to STOP.
  - PARITY: optional; see Optional Feature.
  - STOP: on the tick following sample tick 9, i.e. mid-stop bit:
    - data_byte <= shift register;
    - frame_err <= (stop majority == 0);
    - rx_done = 1 for exactly one clk;
    - return to IDLE.
- Ending at mid-stop allows back-to-back frames with zero idle time.
- data_byte is updated even on frame error. data_byte and the error flags hold until the next rx_done.
- A start edge detected on the same cycle as rx_done is accepted; the next frame begins on the following cycle.
- A line held low through the stop bit produces frame_err=1. The FSM then waits in IDLE for a new start edge; a continuous low does not re-trigger reception.
- Latency: rx_done rises 9.5 bit times (≈ 9.5*16*DIV clk) plus 3 clk after the rs232_rx falling edge. With parity enabled: 10.5 bit times.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between data bit 7 and the stop bit.
  - The parity bit is majority-sampled like the data bits.
  - parity_err <= (XOR of the 8 data bits XOR parity bit) != 0; updated with rx_done.
- Undefined:
  - Frame is 8N1; no PARITY state.
  - parity_err is held at constant 0.

Test Plan:
- baud_set=4, send 0xA5 (8N1) at 115200 → exactly one rx_done pulse ≈ 4104 clk after the start edge, data_byte=0xA5, frame_err=0, uart_state high for the whole frame.
- baud_set=0, send 0x00 then 0xFF back-to-back with no idle bit → two rx_done pulses, data 0x00 then 0xFF, no lost frame.
- Glitch: rs232_rx low for 3 bit-ticks (81 clk at baud_set=4) then high → no rx_done, FSM back to IDLE, uart_state low.
- Send 0x3C with stop bit driven 0 → rx_done=1, data_byte=0x3C, frame_err=1. Next clean frame 0x11 → frame_err=0.
- Assert rst at mid data bit 4 of a 0x55 frame, release, send 0x81 → only one rx_done, data_byte=0x81. All outputs 0 during reset.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 → parity_err=0. Send 0x07 with parity bit 0 → parity_err=1.
